// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier controller.
// Signed RV32M semantics are enabled by the MUL_SIGNED_EN macro.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 5;

  // Two's-complement magnitude when neg is set; 0x80000000 maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_if(logic [31:0] v, logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake bundle between the execute stage and mul_seq_ctrl.
interface mul_seq_ctrl_if;
  import mul_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mul_op_e     req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/mul_seq_ctrl_fulladder_32.sv
// 32-bit ripple-carry adder (no carry-in, no carry-out port); the caller
// reconstructs the carry-out from the operand and sum MSBs.
module fulladder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic [31:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < 31) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative 32x32 shift-add multiplier controller for MUL/MULH/MULHSU/MULHU.
// One ripple adder is reused for 32 accumulate steps, then a FIX cycle
// applies the result sign and selects the word.
// Macro MUL_SIGNED_EN: when defined, signed RV32M semantics; when undefined,
// all high-word ops behave as MULHU (latency unchanged).
module mul_seq_ctrl
  import mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  mul_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  mul_state_e       state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      prod;      // {accumulator, multiplier}; carry lands in bit 63
  logic [31:0]      mcand;
  mul_op_e          op_q;
  logic [31:0]      sum;
  logic             carry;
  logic [31:0]      mag_a, mag_b;
  logic [63:0]      prod_fix;

  fulladder_32 u_add (
    .a   (prod[63:32]),
    .b   (mcand),
    .sum (sum)
  );

  // Carry-out of the accumulate add rebuilt from the MSBs of inputs and sum.
  assign carry = (prod[63] & mcand[31]) | ((prod[63] ^ mcand[31]) & ~sum[31]);

`ifdef MUL_SIGNED_EN
  logic a_neg, b_neg, res_neg;

  // Operand signs per op: rs1 signed for MULH/MULHSU, rs2 signed only for MULH.
  always_comb begin
    a_neg = bus.req_a[31] & ((bus.req_op == MULH) | (bus.req_op == MULHSU));
    b_neg = bus.req_b[31] &  (bus.req_op == MULH);
    mag_a = abs_if(bus.req_a, a_neg);
    mag_b = abs_if(bus.req_b, b_neg);
  end

  // Result sign is captured at accept time and applied in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      res_neg <= 1'b0;
    else if (state == IDLE && bus.req_valid)
      res_neg <= a_neg ^ b_neg;
  end

  assign prod_fix = res_neg ? (~prod + 64'd1) : prod;
`else
  assign mag_a    = bus.req_a;
  assign mag_b    = bus.req_b;
  assign prod_fix = prod;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and request-side handshake; flush wins over every transition.
  always_comb begin
    state_d       = state;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = CALC;
      end
      CALC:    if (cnt == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: operand load, shift-add steps, sign fix and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prod        <= '0;
      mcand       <= '0;
      op_q        <= MUL;
      bus.resp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            mcand <= mag_a;
            prod  <= {32'd0, mag_b};
            cnt   <= '0;
          end
        end
        CALC: begin
          if (prod[0]) prod <= {carry, sum, prod[31:1]};
          else         prod <= {1'b0, prod[63:32], prod[31:1]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          prod            <= prod_fix;
          bus.resp_result <= (op_q == MUL) ? prod_fix[31:0] : prod_fix[63:32];
        end
        default: ;
      endcase
    end
  end

  // resp_valid is a registered copy of "in DONE", so it drops with flush/reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.resp_valid <= 1'b0;
    else        bus.resp_valid <= (state_d == DONE);
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed test-plan steps followed by
// randomized ops, checked against an arithmetic reference model.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  mul_seq_ctrl_if bus();

  mul_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  // Reference: full 64-bit product from plain arithmetic on extended operands.
  function automatic logic [31:0] model(mul_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, ub, ua;
    logic [63:0] p;
    mul_op_e eop;
    eop = op;
`ifndef MUL_SIGNED_EN
    if (op != MUL) eop = MULHU;
`endif
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (eop)
      MULH:    p = sa * sb;
      MULHSU:  p = sa * ub;
      default: p = ua * ub;
    endcase
    return (eop == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Starts just after a negedge: present request, then wait for resp_valid.
  // lat counts rising edges from the accept edge (accept edge = 1).
  task automatic issue(string tag, mul_op_e op, logic [31:0] a, logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check({tag, "_result"}, bus.resp_result, model(op, a, b));
  endtask

  // Response handshake; block must be back in IDLE afterwards.
  task automatic take(string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hits;
    mul_op_e rop;
    logic [31:0] ra, rb, exp_r;

    bus.req_valid  = 1'b0;
    bus.req_op     = MUL;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_result", bus.resp_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic MUL with literal expectation
    issue("mul7x6", MUL, 32'd7, 32'd6);
    check("mul7x6_const", bus.resp_result, 32'h0000_002A);
    take("mul7x6");

    // High-word cases
    issue("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take("mulhu_ff");
    issue("mulh_ff", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MUL_SIGNED_EN
    check("mulh_ff_const", bus.resp_result, 32'h0000_0000);
`else
    check("mulh_ff_const", bus.resp_result, 32'hFFFF_FFFE);
`endif
    take("mulh_ff");
    issue("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000);
    take("mulh_min");
    issue("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take("mulhsu_ff");

    // Backpressure: hold DONE 5 cycles with a stray req_valid pulse
    issue("bp", MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    exp_r = model(MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 32'(bus.resp_valid), 32'd1);
      check("bp_result_hold", bus.resp_result, exp_r);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = (i == 1);
      bus.req_op    = MUL;
      bus.req_a     = 32'd2;
      bus.req_b     = 32'd2;
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    take("bp");
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) hits++;
      @(negedge clk);
    end
    check("bp_no_stray_resp", 32'(hits), 32'd0);

    // Flush at CALC cycle 10
    bus.req_valid = 1'b1;
    bus.req_op    = MUL;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 32'(bus.req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) hits++;
      @(negedge clk);
    end
    check("flush_no_resp", 32'(hits), 32'd0);
    issue("flush_mul3x5", MUL, 32'd3, 32'd5);
    check("flush_mul3x5_const", bus.resp_result, 32'h0000_000F);
    take("flush_mul3x5");

    // Asynchronous reset mid-CALC
    bus.req_valid = 1'b1;
    bus.req_op    = MULHU;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(bus.req_ready), 32'd1);
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_resp_result", bus.resp_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("arst_mulhu", MULHU, 32'h0001_0000, 32'h0001_0000);
    check("arst_mulhu_const", bus.resp_result, 32'h0000_0001);
    take("arst_mulhu");

    // Flush coincident with the DONE handshake
    issue("fh", MULHSU, 32'h8000_0001, 32'h0000_0003);
    bus.resp_ready = 1'b1;
    flush          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    flush          = 1'b0;
    check("fh_valid_drop", 32'(bus.resp_valid), 32'd0);
    issue("fh_next", MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    take("fh_next");

    // Randomized ops with random response delay
    for (int n = 0; n < 24; n++) begin
      rop = mul_op_e'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      issue("rnd", rop, ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_hold", bus.resp_result, model(rop, ra, rb));
      take("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
